neuron_sequencer: RTL and testbench

- Control and configuration block for one stochastic bitstream neuron.
- Holds the neuron's weight and bias register file and reseeds the neuron's generators through its active-low reset.
- Sequences one evaluation: reset pulse, pipeline flush, then a fixed-length counted run.
- Accumulates the neuron's output bitstream into a ones-count and returns it over a valid/ready handshake. Sits between the layer-level scheduler and each neuron instance.

---
 rtl/neuron_ctrl_pkg.sv | 25 ++
 rtl/neuron_sequencer_if.sv | 40 ++++
 rtl/bitstream_counter.sv | 36 +++
 rtl/neuron_sequencer.sv | 162 ++++++++++++++++
 tb/tb_neuron_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_ctrl_pkg.sv
// Shared types and helpers for the neuron sequencer: state encoding,
// config address map and result-width derivation.
package neuron_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Bias register sits directly above the weight registers.
    function automatic int unsigned bias_addr(input int unsigned input_size);
        return input_size;
    endfunction

    // Width needed to hold a ones-count of 0..stream_len inclusive.
    function automatic int unsigned cnt_w(input int unsigned stream_len);
        return $clog2(stream_len + 1);
    endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Scheduler/neuron-facing bundle of the neuron sequencer.
// master: the sequencer (drives config status, neuron controls, result).
// slave : the environment (scheduler + neuron instance).
interface neuron_sequencer_if #(
    parameter int unsigned INPUT_SIZE = 2,
    parameter int unsigned STREAM_LEN = 256
);
    import neuron_ctrl_pkg::*;

    localparam int unsigned AW    = $clog2(INPUT_SIZE + 1);
    localparam int unsigned CNT_W = cnt_w(STREAM_LEN);

    logic                                cfg_we;
    logic [AW-1:0]                       cfg_addr;
    logic [DATA_W-1:0]                   cfg_data;
    logic                                cfg_err;
    logic                                start;
    logic                                busy;
    logic [INPUT_SIZE-1:0][DATA_W-1:0]   weight_values;
    logic [DATA_W-1:0]                   bias_value;
    logic                                nrn_n_rst;
    logic                                stream_en;
    logic                                nrn_out;
    logic                                res_valid;
    logic                                res_ready;
    logic [CNT_W-1:0]                    res_count;

    modport master (
        input  cfg_we, cfg_addr, cfg_data, start, nrn_out, res_ready,
        output cfg_err, busy, weight_values, bias_value, nrn_n_rst,
               stream_en, res_valid, res_count
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_data, start, nrn_out, res_ready,
        input  cfg_err, busy, weight_values, bias_value, nrn_n_rst,
               stream_en, res_valid, res_count
    );

endinterface

// File: rtl/bitstream_counter.sv
// Ones-counter for a bitstream.
// Ports: clk, rst (sync, active-high), clear_i (zero the count),
// en_i (count enable), bit_i (stream bit), count_o (current count).
module bitstream_counter #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && bit_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/neuron_sequencer.sv
// Control/config block for one stochastic bitstream neuron: weight/bias
// register file, reseed-flush-run evaluation sequencing, ones-count result.
// Ports: clk, rst (sync, active-high), bus (neuron_sequencer_if.master):
// config write/err, start/busy, weights/bias, nrn_n_rst/stream_en/nrn_out,
// res_valid/res_ready/res_count.
module neuron_sequencer
    import neuron_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_SIZE   = 2,
    parameter int unsigned STREAM_LEN   = 256,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    neuron_sequencer_if.master  bus
);

    localparam int unsigned CNT_W  = cnt_w(STREAM_LEN);
    localparam int unsigned AW     = $clog2(INPUT_SIZE + 1);
    localparam int unsigned BIAS_A = bias_addr(INPUT_SIZE);
    localparam int unsigned PH_MAX = (STREAM_LEN > FLUSH_CYCLES) ? STREAM_LEN : FLUSH_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SEED  = SEED;
    localparam logic [2:0] ST_FLUSH = FLUSH;
    localparam logic [2:0] ST_RUN   = RUN;
    localparam logic [2:0] ST_DONE  = DONE;

    logic [2:0]                          state_q, state_d;
    logic [PH_W-1:0]                     phase_q, phase_d;
    logic [INPUT_SIZE-1:0][DATA_W-1:0]   weights_q, weights_d;
    logic [DATA_W-1:0]                   bias_q, bias_d;
    logic [CNT_W-1:0]                    res_count_q, res_count_d;
    logic                                cfg_err_q, cfg_err_d;
    logic                                busy_q, busy_d;
    logic                                nrn_n_rst_q, nrn_n_rst_d;
    logic                                stream_en_q, stream_en_d;
    logic                                res_valid_q, res_valid_d;
    logic                                cnt_clear_c, cnt_en_c;
    logic [CNT_W-1:0]                    cnt_c;

    bitstream_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear_c),
        .en_i    (cnt_en_c),
        .bit_i   (bus.nrn_out),
        .count_o (cnt_c)
    );

    // Next-state, register-file and output decode.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        weights_d   = weights_q;
        bias_d      = bias_q;
        res_count_d = res_count_q;
        cfg_err_d   = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;

        // Writes land only in IDLE with a legal address; anything else is flagged.
        if (bus.cfg_we) begin
            if ((state_q == ST_IDLE) && (bus.cfg_addr <= AW'(BIAS_A))) begin
                if (bus.cfg_addr == AW'(BIAS_A)) begin
                    bias_d = bus.cfg_data;
                end else begin
                    for (int i = 0; i < INPUT_SIZE; i++) begin
                        if (bus.cfg_addr == AW'(i)) begin
                            weights_d[i] = bus.cfg_data;
                        end
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_SEED;
                    phase_d     = '0;
                    cnt_clear_c = 1'b1;
                end
            end
            ST_SEED: begin
                state_d = ST_FLUSH;
                phase_d = '0;
            end
            ST_FLUSH: begin
                if (phase_q == PH_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_RUN: begin
                cnt_en_c = 1'b1;
                if (phase_q == PH_W'(STREAM_LEN - 1)) begin
                    // Fold in the final bit, which the counter only sees next edge.
                    res_count_d = cnt_c + CNT_W'(bus.nrn_out);
                    state_d     = ST_DONE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with state_q.
        busy_d      = (state_d != ST_IDLE);
        nrn_n_rst_d = (state_d == ST_FLUSH) || (state_d == ST_RUN) || (state_d == ST_DONE);
        stream_en_d = (state_d == ST_FLUSH) || (state_d == ST_RUN);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            weights_q   <= '0;
            bias_q      <= '0;
            res_count_q <= '0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            nrn_n_rst_q <= 1'b0;
            stream_en_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            weights_q   <= weights_d;
            bias_q      <= bias_d;
            res_count_q <= res_count_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
            nrn_n_rst_q <= nrn_n_rst_d;
            stream_en_q <= stream_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.weight_values = weights_q;
    assign bus.bias_value    = bias_q;
    assign bus.res_count     = res_count_q;
    assign bus.cfg_err       = cfg_err_q;
    assign bus.busy          = busy_q;
    assign bus.nrn_n_rst     = nrn_n_rst_q;
    assign bus.stream_en     = stream_en_q;
    assign bus.res_valid     = res_valid_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: directed sequence with random
// bitstreams, expected counts computed from the stream contents and a
// reseedable LFSR neuron model.
module tb_neuron_sequencer;

    localparam int unsigned IS  = 2;
    localparam int unsigned SL  = 256;
    localparam int unsigned FL  = 2;
    localparam int unsigned NCY = FL + SL + 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    neuron_sequencer_if #(.INPUT_SIZE(IS), .STREAM_LEN(SL)) bus ();

    neuron_sequencer #(
        .INPUT_SIZE   (IS),
        .STREAM_LEN   (SL),
        .FLUSH_CYCLES (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int last_exp = 0;

    logic        bits [0:NCY-1];
    logic [31:0] exp_w [0:IS-1];
    logic [31:0] exp_b;
    logic        use_lfsr;
    logic        pat_bit;
    logic [15:0] lfsr_q;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Neuron stand-in: reseeds while its reset is low, steps otherwise.
    always @(posedge clk) begin
        if (!bus.nrn_n_rst) lfsr_q <= LFSR_SEED;
        else                lfsr_q <= lfsr_next(lfsr_q);
    end

    assign bus.nrn_out = use_lfsr ? lfsr_q[0] : pat_bit;

    // Ones seen in RUN: the neuron has stepped FL times after reseed when RUN begins.
    function automatic int lfsr_expected();
        logic [15:0] x;
        int n;
        x = LFSR_SEED;
        n = 0;
        for (int k = 0; k < int'(FL + SL); k++) begin
            if (k >= int'(FL)) n += int'(x[0]);
            x = lfsr_next(x);
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_wv();
        return {exp_w[1], exp_w[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " weights"}, 64'(bus.weight_values), exp_wv());
        check({tag, " bias"}, 64'(bus.bias_value), 64'(exp_b));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data, input logic exp_err, input string tag);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
        check({tag, " cfg_err"}, 64'(bus.cfg_err), 64'(exp_err));
        if (!exp_err) begin
            if (addr < 2'(IS)) exp_w[addr] = data;
            else               exp_b = data;
        end
        check_regs(tag);
        tick();
        check({tag, " cfg_err pulse end"}, 64'(bus.cfg_err), 64'd0);
    endtask

    // One evaluation; cycle c=0 is SEED, 1..FL flush, FL+1..FL+SL run.
    task automatic run_eval(input string tag, input bit inject_cfg, input int abort_at,
                            input bit cw_start, input logic [31:0] cw_data, input bit lfsr_mode);
        int nlow, nse, nbusy_low, nval, exp_cnt;
        nlow = 0; nse = 0; nbusy_low = 0; nval = 0; exp_cnt = 0;
        use_lfsr = lfsr_mode;
        if (cw_start) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 2'd1;
            bus.cfg_data = cw_data;
            exp_w[1]     = cw_data;
        end
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        if (cw_start) check({tag, " start+cfg no err"}, 64'(bus.cfg_err), 64'd0);
        for (int c = 0; c < int'(NCY); c++) begin
            pat_bit = bits[c];
            if (c >= int'(FL) + 1) exp_cnt += int'(bits[c]);
            if (!bus.nrn_n_rst) nlow++;
            if (bus.stream_en)  nse++;
            if (!bus.busy)      nbusy_low++;
            if (bus.res_valid)  nval++;
            if (c == int'(FL) + 5) check_regs({tag, " in RUN"});
            if (inject_cfg && c == int'(FL) + 50) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'd0;
                bus.cfg_data = $urandom;
            end
            if (inject_cfg && c == int'(FL) + 51) begin
                bus.cfg_we = 1'b0;
                check({tag, " busy write err"}, 64'(bus.cfg_err), 64'd1);
            end
            if (inject_cfg && c == int'(FL) + 52) begin
                check({tag, " busy write err pulse end"}, 64'(bus.cfg_err), 64'd0);
                check_regs({tag, " after busy write"});
            end
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int i = 0; i < int'(IS); i++) exp_w[i] = '0;
                exp_b = '0;
                check({tag, " abort busy"}, 64'(bus.busy), 64'd0);
                check({tag, " abort nrn_n_rst"}, 64'(bus.nrn_n_rst), 64'd0);
                check({tag, " abort stream_en"}, 64'(bus.stream_en), 64'd0);
                check({tag, " abort res_valid"}, 64'(bus.res_valid), 64'd0);
                check_regs({tag, " abort"});
                tick();
                check({tag, " abort no result"}, 64'(bus.res_valid), 64'd0);
                return;
            end
            tick();
        end
        if (lfsr_mode) exp_cnt = lfsr_expected();
        last_exp = exp_cnt;
        check({tag, " nrn_n_rst low cycles"}, 64'(nlow), 64'd1);
        check({tag, " stream_en cycles"}, 64'(nse), 64'(FL + SL));
        check({tag, " busy dropped"}, 64'(nbusy_low), 64'd0);
        check({tag, " early res_valid"}, 64'(nval), 64'd0);
        check({tag, " res_valid at latency"}, 64'(bus.res_valid), 64'd1);
        check({tag, " res_count"}, 64'(bus.res_count), 64'(exp_cnt));
        check({tag, " DONE stream_en"}, 64'(bus.stream_en), 64'd0);
        check({tag, " DONE nrn_n_rst"}, 64'(bus.nrn_n_rst), 64'd1);
    endtask

    task automatic done_handshake(input int hold, input string tag);
        bus.res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.start = (h == 3);
            check({tag, " hold res_valid"}, 64'(bus.res_valid), 64'd1);
            check({tag, " hold res_count"}, 64'(bus.res_count), 64'(last_exp));
            tick();
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, " accept res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, " accept busy"}, 64'(bus.busy), 64'd0);
        check({tag, " accept nrn_n_rst"}, 64'(bus.nrn_n_rst), 64'd0);
        check({tag, " res_count kept"}, 64'(bus.res_count), 64'(last_exp));
        tick();
        check({tag, " no queued start"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        pat_bit       = 1'b0;
        use_lfsr      = 1'b0;
        for (int i = 0; i < int'(IS); i++) exp_w[i] = '0;
        exp_b = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst nrn_n_rst", 64'(bus.nrn_n_rst), 64'd0);
        check("rst stream_en", 64'(bus.stream_en), 64'd0);
        check("rst res_valid", 64'(bus.res_valid), 64'd0);
        check("rst cfg_err", 64'(bus.cfg_err), 64'd0);
        check("rst res_count", 64'(bus.res_count), 64'd0);
        check_regs("rst");
        rst = 1'b0;
        tick();

        // res_ready with nothing pending does nothing
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("idle ready busy", 64'(bus.busy), 64'd0);
        check("idle ready valid", 64'(bus.res_valid), 64'd0);

        // Random config traffic, including illegal address 3
        for (int k = 0; k < 6; k++) begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            cfg_write(a, $urandom, (a == 2'd3), "rand cfg");
        end

        // Directed config then all-ones run with a held handshake
        cfg_write(2'd0, 32'd128, 1'b0, "w0");
        cfg_write(2'd1, 32'd64, 1'b0, "w1");
        cfg_write(2'd2, 32'd32, 1'b0, "bias");
        cfg_write(2'd3, 32'd777, 1'b1, "bad addr");
        for (int c = 0; c < int'(NCY); c++) bits[c] = 1'b1;
        run_eval("ones", 1'b0, -1, 1'b0, 32'd0, 1'b0);
        check("ones = STREAM_LEN", 64'(last_exp), 64'(SL));
        done_handshake(10, "ones hs");

        // Alternating 1,0 from the first RUN cycle, with a rejected busy write
        for (int c = 0; c < int'(NCY); c++)
            bits[c] = (c >= int'(FL) + 1) ? logic'(((c - int'(FL) - 1) % 2) == 0) : 1'b0;
        run_eval("toggle", 1'b1, -1, 1'b0, 32'd0, 1'b0);
        done_handshake(0, "toggle hs");
        check_regs("after toggle");

        // Ones only during seed/flush, plus a write issued together with start
        for (int c = 0; c < int'(NCY); c++) bits[c] = (c <= int'(FL));
        run_eval("flush only", 1'b0, -1, 1'b1, $urandom, 1'b0);
        check("flush only = 0", 64'(last_exp), 64'd0);
        done_handshake(0, "flush hs");

        // Random stream aborted by reset at RUN cycle 100
        for (int c = 0; c < int'(NCY); c++) bits[c] = 1'($urandom);
        run_eval("abort", 1'b0, int'(FL) + 1 + 100, 1'b0, 32'd0, 1'b0);

        // Restart with ready held high and no config since reset
        for (int c = 0; c < int'(NCY); c++) bits[c] = 1'($urandom);
        bus.res_ready = 1'b1;
        run_eval("restart", 1'b0, -1, 1'b0, 32'd0, 1'b0);
        done_handshake(0, "restart hs");

        // Reseed determinism with the LFSR neuron, two back-to-back runs
        for (int r = 0; r < 2; r++) begin
            run_eval("reseed", 1'b0, -1, 1'b0, 32'd0, 1'b1);
            done_handshake(0, "reseed hs");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
